// File: rtl/clock_pkg.sv
// Shared widths, limits and hour-format helper
// for the time-of-day counter slice.
package clock_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  // Returns {pm, hours_12h} for a 0..23 hour value.
  function automatic logic [HOUR_W:0] to_12h(
    input logic [HOUR_W-1:0] h24
  );
    logic              pm_b;
    logic [HOUR_W-1:0] h12;
    pm_b = (h24 >= 5'd12);
    unique case (1'b1)
      (h24 == 5'd0) || (h24 == 5'd12): h12 = 5'd12;
      (h24 > 5'd12):                    h12 = h24 - 5'd12;
      default:                          h12 = h24;
    endcase
    return {pm_b, h12};
  endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Control and display bundle between the
// board logic and the time-of-day counter.
interface time_of_day_counter_if;
  import clock_pkg::*;

  logic              on;
  logic [5:0]        time_set;
  logic              hour_set;
  logic              minute_set;
  logic              mode_12h;
  logic [SEC_W-1:0]  seconds;
  logic [MIN_W-1:0]  minutes;
  logic [HOUR_W-1:0] hours;
  logic              pm;
  logic              sec_tick;
  logic              set_err;

  modport master (
    output on, time_set, hour_set,
    output minute_set, mode_12h,
    input  seconds, minutes, hours,
    input  pm, sec_tick, set_err
  );

  modport slave (
    input  on, time_set, hour_set,
    input  minute_set, mode_12h,
    output seconds, minutes, hours,
    output pm, sec_tick, set_err
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with load and an
// equality-based carry out.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry
);

  assign carry = inc && (q == W'(MAX));

  // Load wins over increment; wrap only on equality with MAX.
  always_ff @(posedge clk) begin
    if (!rstn)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (inc)
      q <= carry ? '0 : q + W'(1);
  end

endmodule

// File: rtl/time_of_day_counter.sv
// Single-clock prescaler + sec/min/hour chain
// with field-wise setting and 12/24 h display.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 32768
) (
  input logic                 clk,
  input logic                 rstn,
  time_of_day_counter_if.slave bus
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic              m_ok, h_ok;
  logic              m_load, h_load;
  logic              run, tick;
  logic              sec_carry, min_carry, hour_carry;
  logic [PRE_W-1:0]  pre_q;
  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hour_q;
  logic [HOUR_W:0]   map12;
  logic              tick_q, err_q;
  logic              unused_ok;

  assign m_ok   = bus.time_set <= 6'(MIN_MAX);
  assign h_ok   = bus.time_set <= 6'(HOUR_MAX);
  assign m_load = bus.minute_set && m_ok;
  assign h_load = bus.hour_set && h_ok;
  assign run    = bus.on && !bus.minute_set;

  mod_counter #(.MAX(TICK_DIV-1), .W(PRE_W)) u_pre (
    .clk(clk), .rstn(rstn),
    .inc(run), .load(m_load),
    .load_val('0),
    .q(pre_q), .carry(tick)
  );

  mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk(clk), .rstn(rstn),
    .inc(tick), .load(m_load),
    .load_val('0),
    .q(sec_q), .carry(sec_carry)
  );

  mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk(clk), .rstn(rstn),
    .inc(sec_carry), .load(m_load),
    .load_val(bus.time_set),
    .q(min_q), .carry(min_carry)
  );

  mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk(clk), .rstn(rstn),
    .inc(min_carry && !bus.hour_set),
    .load(h_load),
    .load_val(bus.time_set[HOUR_W-1:0]),
    .q(hour_q), .carry(hour_carry)
  );

  assign unused_ok = &{1'b0, pre_q, hour_carry};

  // Registered tick and range-error pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tick_q <= tick;
      err_q  <= (bus.minute_set && !m_ok) ||
                (bus.hour_set && !h_ok);
    end
  end

  assign map12        = to_12h(hour_q);
  assign bus.seconds  = sec_q;
  assign bus.minutes  = min_q;
  assign bus.hours    = bus.mode_12h ? map12[HOUR_W-1:0] : hour_q;
  assign bus.pm       = map12[HOUR_W];
  assign bus.sec_tick = tick_q;
  assign bus.set_err  = err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench: time-of-day counter against a
// seconds-of-day reference model.
module tb_time_of_day_counter;

  localparam int TD = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  time_of_day_counter_if bus();

  time_of_day_counter #(.TICK_DIV(TD)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  int p       = 0;
  bit e_tick  = 1'b0;
  bit e_err   = 1'b0;

  task automatic chk(string nm, logic [31:0] act, int exp);
    n_tests++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: time kept as seconds since midnight.
  task automatic model_edge();
    int h, m, s, tn, ts;
    if (!rstn) begin
      t = 0; p = 0; e_tick = 0; e_err = 0;
      return;
    end
    ts = int'(bus.time_set);
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    e_tick = 0;
    e_err = (bus.minute_set && ts > 59) ||
            (bus.hour_set && ts > 23);
    if (bus.minute_set) begin
      if (ts <= 59) begin
        m = ts; s = 0; p = 0;
      end
    end else if (bus.on) begin
      if (p == TD - 1) begin
        p = 0;
        e_tick = 1;
        tn = (t + 1) % 86400;
        m = (tn / 60) % 60;
        s = tn % 60;
        if (!bus.hour_set) h = tn / 3600;
      end else begin
        p++;
      end
    end
    if (bus.hour_set && ts <= 23) h = ts;
    t = h * 3600 + m * 60 + s;
  endtask

  task automatic compare();
    int h24, eh;
    h24 = t / 3600;
    if (bus.mode_12h)
      eh = (h24 % 12 == 0) ? 12 : h24 % 12;
    else
      eh = h24;
    chk("seconds", 32'(bus.seconds), t % 60);
    chk("minutes", 32'(bus.minutes), (t / 60) % 60);
    chk("hours", 32'(bus.hours), eh);
    chk("pm", 32'(bus.pm), (h24 >= 12) ? 1 : 0);
    chk("sec_tick", 32'(bus.sec_tick), int'(e_tick));
    chk("set_err", 32'(bus.set_err), int'(e_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_min(int v);
    bus.minute_set = 1'b1;
    bus.time_set = 6'(v);
    cycle();
    bus.minute_set = 1'b0;
  endtask

  task automatic set_hour(int v);
    bus.hour_set = 1'b1;
    bus.time_set = 6'(v);
    cycle();
    bus.hour_set = 1'b0;
  endtask

  initial begin
    int cnt, i1, i2, t0;
    bus.on = 1'b0;
    bus.time_set = '0;
    bus.hour_set = 1'b0;
    bus.minute_set = 1'b0;
    bus.mode_12h = 1'b0;

    rstn = 1'b0;
    cycle();
    cycle();
    chk("reset_hours", 32'(bus.hours), 0);
    rstn = 1'b1;

    // First seconds after reset.
    bus.on = 1'b1;
    cnt = 0; i1 = -1; i2 = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (bus.sec_tick) begin
        if (cnt == 0) i1 = i; else i2 = i;
        cnt++;
      end
    end
    chk("tick_count", 32'(cnt), 2);
    chk("tick_gap", 32'(i2 - i1), 4);
    chk("first_seconds", 32'(bus.seconds), 2);
    chk("first_minutes", 32'(bus.minutes), 0);

    // Midnight rollover.
    set_hour(23);
    set_min(59);
    for (int i = 0; i < 59 * TD; i++) cycle();
    chk("pre_roll_h", 32'(bus.hours), 23);
    chk("pre_roll_m", 32'(bus.minutes), 59);
    chk("pre_roll_s", 32'(bus.seconds), 59);
    chk("pre_roll_pm", 32'(bus.pm), 1);
    for (int i = 0; i < TD; i++) cycle();
    chk("roll_h", 32'(bus.hours), 0);
    chk("roll_m", 32'(bus.minutes), 0);
    chk("roll_s", 32'(bus.seconds), 0);
    chk("roll_pm", 32'(bus.pm), 0);
    chk("roll_tick", 32'(bus.sec_tick), 1);

    // Minute range check.
    set_min(60);
    chk("err60", 32'(bus.set_err), 1);
    chk("err60_min", 32'(bus.minutes), 0);
    cycle();
    chk("err60_pulse", 32'(bus.set_err), 0);
    set_min(30);
    chk("set30_min", 32'(bus.minutes), 30);
    chk("set30_sec", 32'(bus.seconds), 0);
    chk("set30_err", 32'(bus.set_err), 0);

    // Both fields with 45.
    bus.hour_set = 1'b1;
    set_min(45);
    bus.hour_set = 1'b0;
    chk("both_min", 32'(bus.minutes), 45);
    chk("both_hour", 32'(bus.hours), 0);
    chk("both_err", 32'(bus.set_err), 1);

    // 12 h mapping.
    bus.mode_12h = 1'b1;
    set_hour(0);
    chk("h12_0", {26'd0, bus.pm, bus.hours}, 12);
    set_hour(12);
    chk("h12_12", {26'd0, bus.pm, bus.hours}, 32 + 12);
    set_hour(13);
    chk("h12_13", {26'd0, bus.pm, bus.hours}, 32 + 1);
    set_hour(23);
    chk("h12_23", {26'd0, bus.pm, bus.hours}, 32 + 11);

    // Hold, then reset mid-count.
    bus.on = 1'b0;
    t0 = t;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.sec_tick) cnt++;
    end
    chk("hold_ticks", 32'(cnt), 0);
    chk("hold_sec", 32'(bus.seconds), t0 % 60);
    chk("hold_min", 32'(bus.minutes), (t0 / 60) % 60);
    bus.on = 1'b1;
    bus.mode_12h = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    chk("rst_sec", 32'(bus.seconds), 0);
    chk("rst_min", 32'(bus.minutes), 0);
    chk("rst_hour", 32'(bus.hours), 0);
    chk("rst_tick", 32'(bus.sec_tick), 0);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      bus.on = ($urandom_range(0, 9) != 0);
      bus.minute_set = ($urandom_range(0, 24) == 0);
      bus.hour_set = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: bus.time_set = 6'd59;
        1: bus.time_set = 6'd23;
        default: bus.time_set = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 15) == 0)
        bus.mode_12h = ~bus.mode_12h;
      rstn = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
